// File: rtl/adc_lvds_rx.sv
// adc_lvds_rx
//
// FPGA-side receiver for ADS1675-class sigma-delta ADCs running in
// high-speed LVDS mode without SCLK/DRDY routed to the FPGA. The block
// raises the ADC START pin, counts the digital filter settling interval
// in bit strobes, skips a programmable number of extra strobes to set
// the word phase, then frames the continuous MSB-first stream on NCH
// lanes into parallel sign-extended samples. Samples are buffered in a
// small FIFO behind a valid/ready port.
//
// Ports:
//   clk        single clock (ADC bit clock domain)
//   arst_n     asynchronous, active-low reset
//   bit_en     one-cycle strobe: din is sampled on this clk edge
//   din        serial data, one bit per lane
//   run        level, 1 = acquire, 0 = stop
//   align      extra strobes skipped after settling (word phase)
//   adc_start  drives the ADC START pin
//   m_valid    sample word available
//   m_data     lane k in bits [k*OW +: OW]
//   m_ready    consumer accepts on m_valid & m_ready
//   ovf        sticky: a sample was dropped on a full FIFO
//   smp_cnt    samples pushed since the last run rise (wraps)

module adc_lvds_rx #(
    parameter int NCH    = 1,
    parameter int SW     = 24,
    parameter int OW     = 32,
    parameter int SETTLE = 1324,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              bit_en,
    input  logic [NCH-1:0]    din,
    input  logic              run,
    input  logic [4:0]        align,
    output logic              adc_start,
    output logic              m_valid,
    output logic [NCH*OW-1:0] m_data,
    input  logic              m_ready,
    output logic              ovf,
    output logic [31:0]       smp_cnt
);

    localparam int BW = $clog2(SW);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ALIGN,
        S_STREAM
    } state_t;

    state_t             state;
    logic [31:0]        cnt;
    logic [BW-1:0]      bitcnt;
    logic [SW-1:0]      shreg [NCH];

    logic [NCH*OW-1:0]  push_word;
    logic               push;
    logic               pop;
    logic               push_ok;

    logic [NCH*OW-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        count_next;

    // The completed word includes the bit being strobed right now, so it is
    // assembled from the shift register plus din rather than from shreg alone.
    always_comb begin
        logic [SW-1:0] lane_bits;
        push_word = '0;
        for (int k = 0; k < NCH; k++) begin
            lane_bits = {shreg[k][SW-2:0], din[k]};
            push_word[k*OW +: OW] = OW'($signed(lane_bits));
        end
    end

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    always_comb begin
        push    = (state == S_STREAM) && run && bit_en && (bitcnt == BW'(SW - 1));
        pop     = m_valid && m_ready;
        push_ok = push && (!count[AW] || pop);
    end

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Control FSM: START pin, settle/align counting, framing, sample statistics.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            adc_start <= 1'b0;
            ovf       <= 1'b0;
            smp_cnt   <= '0;
            for (int k = 0; k < NCH; k++) begin
                shreg[k] <= '0;
            end
        end else begin
            if (push) begin
                if (push_ok) begin
                    smp_cnt <= smp_cnt + 32'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end

            if (state != S_IDLE && !run) begin
                // Stopping throws away any partially framed word.
                state     <= S_IDLE;
                adc_start <= 1'b0;
                bitcnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            state     <= S_SETTLE;
                            cnt       <= 32'(SETTLE - 1);
                            adc_start <= 1'b1;
                            ovf       <= 1'b0;
                            smp_cnt   <= '0;
                            bitcnt    <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (bit_en) begin
                            if (cnt == 32'd0) begin
                                if (align == 5'd0) begin
                                    state <= S_STREAM;
                                end else begin
                                    state <= S_ALIGN;
                                    cnt   <= {27'd0, align};
                                end
                            end else begin
                                cnt <= cnt - 32'd1;
                            end
                        end
                    end
                    S_ALIGN: begin
                        if (bit_en) begin
                            if (cnt == 32'd1) begin
                                state <= S_STREAM;
                            end else begin
                                cnt <= cnt - 32'd1;
                            end
                        end
                    end
                    S_STREAM: begin
                        if (bit_en) begin
                            for (int k = 0; k < NCH; k++) begin
                                shreg[k] <= {shreg[k][SW-2:0], din[k]};
                            end
                            if (bitcnt == BW'(SW - 1)) begin
                                bitcnt <= '0;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Sample FIFO. Storage is reset so m_data reads zero out of reset;
    // m_valid is a flop kept equal to (occupancy != 0).
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                mem[d] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            m_valid <= (count_next != '0);
        end
    end

    assign m_data = mem[rd_ptr];

endmodule

// File: tb/tb_adc_lvds_rx.sv
// tb_adc_lvds_rx
//
// Directed bench for adc_lvds_rx with NCH=2, SW=24, SETTLE=9, DEPTH=4 and
// bit_en every third clock. An ADC stand-in drives the lanes once START
// is high: ones during settling, then back-to-back 24-bit words where
// lane0 word w = 0x7FFFF0 + w and lane1 is its bitwise complement.
// Inputs change 1-2 time units after the rising edge; outputs are
// sampled on the falling edge.

module tb_adc_lvds_rx;

    localparam int NCH    = 2;
    localparam int SW     = 24;
    localparam int OW     = 32;
    localparam int SETTLE = 9;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              arst_n;
    logic              bit_en;
    logic [NCH-1:0]    din;
    logic              run;
    logic [4:0]        align;
    logic              adc_start;
    logic              m_valid;
    logic [NCH*OW-1:0] m_data;
    logic              m_ready;
    logic              ovf;
    logic [31:0]       smp_cnt;

    int checks;
    int errors;
    int sidx;
    logic [NCH*OW-1:0] got_q [$];

    typedef struct {
        int          align_v;
        int          idx;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [6];

    adc_lvds_rx #(
        .NCH    (NCH),
        .SW     (SW),
        .OW     (OW),
        .SETTLE (SETTLE),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .bit_en    (bit_en),
        .din       (din),
        .run       (run),
        .align     (align),
        .adc_start (adc_start),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .ovf       (ovf),
        .smp_cnt   (smp_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stream model: what the ADC puts on the wire.
    function automatic logic [23:0] adc_word(input int lane, input int w);
        logic [23:0] v;
        v = 24'h7FFFF0 + 24'(w);
        return (lane == 0) ? v : ~v;
    endfunction

    function automatic logic stream_bit(input int lane, input int p);
        logic [23:0] w;
        w = adc_word(lane, p / 24);
        return w[23 - (p % 24)];
    endfunction

    function automatic logic [31:0] exp_word(input int lane, input int a, input int j);
        logic [23:0] r;
        r = '0;
        for (int b = 0; b < 24; b++) begin
            r = {r[22:0], stream_bit(lane, a + 24 * j + b)};
        end
        return {{8{r[23]}}, r};
    endfunction

    function automatic logic [63:0] exp_pair(input int a, input int j);
        return {exp_word(1, a, j), exp_word(0, a, j)};
    endfunction

    // ADC stand-in: strobes count from START rising; data follows settling.
    initial begin
        int phase;
        int p;
        phase  = 0;
        sidx   = 0;
        bit_en = 1'b0;
        din    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!adc_start) sidx = 0;
            if (phase == 0) begin
                bit_en = 1'b1;
                if (adc_start) begin
                    sidx = sidx + 1;
                    p = sidx - SETTLE - 1;
                    for (int k = 0; k < NCH; k++) begin
                        din[k] = (p < 0) ? 1'b1 : stream_bit(k, p);
                    end
                end
            end else begin
                bit_en = 1'b0;
            end
            phase = (phase == 2) ? 0 : phase + 1;
        end
    end

    // Record every accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at posedge+2 with bit_en already set for strobe n on the next edge.
    task automatic wait_strobe(input int n);
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            #2;
            if (sidx == n && bit_en) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_strobe_%0d: timeout, at strobe %0d", n, sidx);
    endtask

    task automatic wait_words(input int n);
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            #2;
            if (got_q.size() >= n) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_words_%0d: timeout, have %0d", n, got_q.size());
    endtask

    task automatic check_table(input int a);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].align_v == a) begin
                if (vecs[i].idx < got_q.size()) begin
                    check_output($sformatf("table_a%0d_w%0d", a, vecs[i].idx),
                                 got_q[vecs[i].idx], {vecs[i].exp1, vecs[i].exp0});
                end else begin
                    check_output($sformatf("table_a%0d_w%0d_present", a, vecs[i].idx),
                                 64'(got_q.size()), 64'(vecs[i].idx + 1));
                end
            end
        end
    endtask

    task automatic check_stream(input int a, input int n);
        for (int j = 0; j < n && j < got_q.size(); j++) begin
            check_output($sformatf("stream_a%0d_w%0d", a, j), got_q[j], exp_pair(a, j));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_adc_start"}, 64'(adc_start), 64'd0);
        check_output({tag, "_m_valid"},   64'(m_valid),   64'd0);
        check_output({tag, "_m_data"},    m_data,         64'd0);
        check_output({tag, "_ovf"},       64'(ovf),       64'd0);
        check_output({tag, "_smp_cnt"},   64'(smp_cnt),   64'd0);
    endtask

    initial begin
        int drain_idx [5];

        vecs[0] = '{0,  0, 32'h007FFFF0, 32'hFF80000F};
        vecs[1] = '{0, 15, 32'h007FFFFF, 32'hFF800000};
        vecs[2] = '{0, 16, 32'hFF800000, 32'h007FFFFF};
        vecs[3] = '{5,  0, 32'hFFFFFE0F, 32'h000001F0};
        vecs[4] = '{5, 14, 32'hFFFFFFCF, 32'h00000030};
        vecs[5] = '{5, 15, 32'hFFFFFFF0, 32'h0000000F};
        drain_idx = '{0, 1, 2, 3, 6};

        checks  = 0;
        errors  = 0;
        arst_n  = 1'b0;
        run     = 1'b0;
        align   = 5'd0;
        m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #2;

        // Run 1: align 0, free-running consumer.
        $display("[TB] run 1: align=0");
        align = 5'd0;
        run   = 1'b1;
        @(negedge clk);
        check_output("adc_start_before_edge", 64'(adc_start), 64'd0);
        @(negedge clk);
        check_output("adc_start_rise", 64'(adc_start), 64'd1);
        wait_strobe(SETTLE + SW);
        @(negedge clk);
        check_output("first_word_not_early", 64'(m_valid), 64'd0);
        @(negedge clk);
        check_output("first_word_valid", 64'(m_valid), 64'd1);
        check_output("first_word_smp_cnt", 64'(smp_cnt), 64'd1);
        check_output("first_word_data", m_data, exp_pair(0, 0));

        // Drop run 10 bits into word 17.
        wait_strobe(SETTLE + 24 * 17 + 10);
        @(posedge clk);
        #2;
        run = 1'b0;
        @(negedge clk);
        check_output("adc_start_hold", 64'(adc_start), 64'd1);
        @(negedge clk);
        check_output("adc_start_fall", 64'(adc_start), 64'd0);
        repeat (20) @(posedge clk);
        #2;
        check_output("run1_word_count", 64'(got_q.size()), 64'd17);
        check_output("run1_smp_cnt", 64'(smp_cnt), 64'd17);
        check_table(0);
        check_stream(0, 17);

        // Run 2: align 5, full settle repeated, partial word forgotten.
        $display("[TB] run 2: align=5");
        got_q.delete();
        align = 5'd5;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("restart_adc_start", 64'(adc_start), 64'd1);
        check_output("restart_smp_cnt_clear", 64'(smp_cnt), 64'd0);
        check_output("restart_ovf", 64'(ovf), 64'd0);
        wait_strobe(SETTLE + 5 + SW);
        @(negedge clk);
        check_output("align5_smp_cnt_before", 64'(smp_cnt), 64'd0);
        @(negedge clk);
        check_output("align5_smp_cnt_after", 64'(smp_cnt), 64'd1);
        wait_words(16);
        check_table(5);
        check_stream(5, 16);
        run = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        // Run 3: consumer stalled for 6 words.
        $display("[TB] run 3: backpressure");
        m_ready = 1'b0;
        got_q.delete();
        align = 5'd0;
        run   = 1'b1;
        wait_strobe(SETTLE + 24 * 6);
        @(negedge clk);
        @(negedge clk);
        check_output("bp_m_valid", 64'(m_valid), 64'd1);
        check_output("bp_ovf", 64'(ovf), 64'd1);
        check_output("bp_smp_cnt", 64'(smp_cnt), 64'd4);
        check_output("bp_head_stable", m_data, exp_pair(0, 0));
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        wait_words(5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check_output($sformatf("bp_drain_%0d", i), got_q[i], exp_pair(0, drain_idx[i]));
        end
        run = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        // Run 4: push and pop on the same edge with the FIFO full.
        $display("[TB] run 4: full push/pop, then async reset");
        m_ready = 1'b0;
        got_q.delete();
        run = 1'b1;
        wait_strobe(SETTLE + 24 * 4);
        @(negedge clk);
        @(negedge clk);
        check_output("full_smp_cnt", 64'(smp_cnt), 64'd4);
        wait_strobe(SETTLE + 24 * 5);
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        @(negedge clk);
        check_output("pushpop_ovf", 64'(ovf), 64'd0);
        check_output("pushpop_smp_cnt", 64'(smp_cnt), 64'd5);
        check_output("pushpop_popped", 64'(got_q.size()), 64'd1);
        check_output("pushpop_new_head", m_data, exp_pair(0, 1));
        check_output("pushpop_m_valid", 64'(m_valid), 64'd1);

        // Asynchronous reset mid-cycle while streaming with m_valid high.
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #2;
        arst_n  = 1'b1;
        m_ready = 1'b1;
        got_q.delete();
        @(negedge clk);
        check_output("post_reset_adc_start_low", 64'(adc_start), 64'd0);
        @(negedge clk);
        check_output("post_reset_adc_start_high", 64'(adc_start), 64'd1);
        wait_strobe(SETTLE + SW);
        @(negedge clk);
        check_output("post_reset_not_early", 64'(m_valid), 64'd0);
        @(negedge clk);
        check_output("post_reset_valid", 64'(m_valid), 64'd1);
        check_output("post_reset_data", m_data, exp_pair(0, 0));
        check_output("post_reset_smp_cnt", 64'(smp_cnt), 64'd1);

        run = 1'b0;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_lvds_rx.md
# adc_lvds_rx

Synthesizable multi-lane receiver for ADS1675-class sigma-delta ADCs operating in high-speed LVDS mode on boards that route neither SCLK nor DRDY to the FPGA. The block drives the ADC START pin, counts the filter settling interval, and frames the continuous MSB-first bit stream on NCH lanes into parallel samples. It buffers the samples in a small FIFO behind a valid/ready port toward the DSP/packet path, and serves as the FPGA-side counterpart to the ADC bus functional model.

## Interface
- NCH, 1: number of ADC lanes, sampled in lock-step (1..8)
- SW, 24: bits per sample on the wire (8..32)
- OW, 32: output width per channel, OW ≥ SW; sample sign-extended from bit SW-1
- SETTLE, 1324: bit strobes from START rise until the first valid bit; ≥ 2
- DEPTH, 4: FIFO depth in samples, power of 2, ≥ 2

- clk  in  1  single clock for all logic; ADC bit clock domain
- arst_n  in  1  asynchronous, active-low reset
- bit_en  in  1  one-cycle strobe marking the clk edge on which din is sampled
- din  in  NCH  serial data, one bit per lane, already LVDS-received
- run  in  1  level: 1 = acquire, 0 = stop
- align  in  5  extra bit strobes skipped after SETTLE; sets word phase (0..31)
- adc_start  out  1  to ADC START pin
- m_valid  out  1  sample word available
- m_data  out  NCH*OW  lane k in bits [k*OW +: OW]
- m_ready  in  1  consumer accepts on m_valid & m_ready
- ovf  out  1  sticky: a sample was dropped because the FIFO was full
- smp_cnt  out  32  samples pushed since the last run rise; wraps at 2^32

## Operation
- Reset values: adc_start=0, m_valid=0, m_data=0, ovf=0, smp_cnt=0; state IDLE; FIFO empty.
- FSM states:
  - IDLE: adc_start=0. On run=1, go to SETTLE, load cnt=SETTLE-1, set adc_start=1, clear ovf and smp_cnt.
  - SETTLE: on each bit_en, cnt decrements. The bit_en that sees cnt==0 goes to ALIGN with cnt=align (latched at this point), or directly to STREAM if align==0.
  - ALIGN: on each bit_en, cnt decrements. The bit_en that sees cnt==1 goes to STREAM.
  - STREAM: on each bit_en, shift din[k] into the LSB of shreg[k] and increment bitcnt. On the SW-th bit, push the {sign-extended shreg} word with that bit included, then set bitcnt=0.
- run=0 in any non-IDLE state: next cycle go to IDLE, adc_start=0, discard the partial word. FIFO contents are kept and continue to drain.
- Push with FIFO full: word dropped, ovf=1, smp_cnt not incremented.
- Push and pop in the same cycle with FIFO full: the pop frees the slot and the push succeeds.
- smp_cnt increments on every successful push and wraps from 0xFFFF_FFFF to 0.
- Sign extension: bits [OW-1:SW] of each lane equal bit SW-1.
- Lanes share bitcnt; there is no per-lane alignment.

## Timing
- adc_start rises 1 clk after run rises and falls 1 clk after run falls.
- The first captured bit is at bit strobe number SETTLE+align+1 counted after the adc_start rise.
- Data latency: the last bit of a word is strobed at edge N; m_valid=1 at N+1 when the FIFO was empty (registered output, no bypass).
- m_data is stable while m_valid=1 and m_ready=0.
- bit_en may be continuous (1 every clk); back-to-back words carry no gap bits.
- bit_en while in IDLE is ignored.
- Mid-operation asynchronous reset returns every output to its reset value immediately.

## Test plan
- NCH=2, SW=24, SETTLE=9, align=0, bit_en every 3rd clk. Lanes feed the counter pattern 0x7FFFF0.., 0x800000 -> first m_data lane0 = 0x007FFFF0 and 0x800000 returns 0xFF800000; first word arrives after exactly 9+24 strobes.
- align=5 against the same stream: the captured word equals the stream rotated by 5 bits; smp_cnt=1 after 9+5+24 strobes.
- m_ready=0 with DEPTH=4 for 6 words -> m_valid held, 4 words kept in order, ovf=1, smp_cnt=4; on releasing m_ready, 4 words drain and are followed by new data.
- Full FIFO with push and pop in the same cycle -> no drop, ovf stays 0, smp_cnt increments.
- run dropped 10 bits into a word, then raised again -> partial word discarded, adc_start low for ≥1 clk, ovf and smp_cnt cleared, full SETTLE repeated.
- arst_n pulsed during STREAM with m_valid=1 -> all outputs 0 asynchronously; normal restart when run=1.
